// File: rtl/difftest_core_sync_ctrl.sv
// Multi-core step/exit scheduler feeding the single difftest endpoint.
// Optional perf counters are enabled by defining DIFFTEST_SYNC_PERF_EN.
module difftest_core_sync_ctrl #(
  parameter int unsigned NUM_CORES   = 2,
  parameter int unsigned STEP_WIDTH  = 8,
  parameter int unsigned PEND_WIDTH  = 32,
  parameter int unsigned STUCK_WIDTH = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_CORES*STEP_WIDTH-1:0] core_step,
  input  logic [NUM_CORES*64-1:0]         core_exit,
  input  logic [7:0]                      simv_result,
  input  logic [STUCK_WIDTH-1:0]          stuck_limit,
  output logic [STEP_WIDTH-1:0]           step_out,
  output logic [63:0]                     exit_out,
  output logic [1:0]                      state_out,
  output logic                            stall,
  output logic [NUM_CORES-1:0]            stuck_core
`ifdef DIFFTEST_SYNC_PERF_EN
  ,
  output logic [63:0]                     perf_run_cycles,
  output logic [63:0]                     perf_total_steps,
  output logic                            perf_dump
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FAIL  = 2'd3;

  localparam int unsigned SUM_WIDTH = PEND_WIDTH + 1;
  localparam logic [PEND_WIDTH-1:0] STEP_MAX = PEND_WIDTH'({STEP_WIDTH{1'b1}});

  logic [1:0]             state_d;
  logic [PEND_WIDTH-1:0]  pending_q, pending_d;
  logic [STEP_WIDTH-1:0]  step_d, emit;
  logic [63:0]            exit_d;
  logic                   stall_d;
  logic [NUM_CORES-1:0]   done_q, done_d;
  logic [NUM_CORES-1:0]   fire, stuck_d, new_stuck;
  logic [STUCK_WIDTH-1:0] timer_q [NUM_CORES];
  logic [STUCK_WIDTH-1:0] timer_d [NUM_CORES];
  logic [SUM_WIDTH-1:0]   sum, avail_w;
  logic [PEND_WIDTH-1:0]  avail;
  logic                   err;
  logic [63:0]            err_code;

  // Per-core bookkeeping: step sum, done bits, watchdog timers, error pick.
  always_comb begin
    sum    = '0;
    done_d = done_q;
    fire   = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      sum = sum + SUM_WIDTH'(core_step[i*STEP_WIDTH +: STEP_WIDTH]);
      if (core_exit[i*64 +: 64] == '1) begin
        done_d[i] = 1'b1;
      end
      if (core_step[i*STEP_WIDTH +: STEP_WIDTH] != '0 || done_q[i]) begin
        timer_d[i] = '0;
      end else if (timer_q[i] != '1) begin
        timer_d[i] = timer_q[i] + STUCK_WIDTH'(1);
      end else begin
        timer_d[i] = timer_q[i];
      end
      fire[i] = (stuck_limit != '0) && (timer_q[i] >= stuck_limit);
    end
    stuck_d   = stuck_core | fire;
    new_stuck = fire & ~stuck_core;

    // Descending scan so the lowest erroring core overwrites last.
    err      = 1'b0;
    err_code = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (!done_q[i] && core_exit[i*64 +: 64] != '0 && core_exit[i*64 +: 64] != '1) begin
        err      = 1'b1;
        err_code = core_exit[i*64 +: 64];
      end
    end
  end

  // Step merge: new steps only enter while running; excess is carried.
  always_comb begin
    avail_w = {1'b0, pending_q} + ((state_out == ST_RUN) ? sum : '0);
    avail   = avail_w[PEND_WIDTH] ? '1 : avail_w[PEND_WIDTH-1:0];
    if (avail >= STEP_MAX) begin
      emit = '1;
    end else begin
      emit = avail[STEP_WIDTH-1:0];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_out;
    exit_d    = '0;
    step_d    = emit;
    pending_d = avail - PEND_WIDTH'(emit);
    case (state_out)
      ST_RUN: begin
        if (simv_result == 8'd2) begin
          state_d = ST_FAIL;
          exit_d  = 64'h2;
        end else if (err) begin
          state_d = ST_FAIL;
          exit_d  = err_code;
        end else if (|new_stuck) begin
          state_d = ST_FAIL;
          exit_d  = 64'h5;
        end else if (simv_result == 8'd1 || &done_d) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (simv_result == 8'd2) begin
          state_d = ST_FAIL;
          exit_d  = 64'h2;
        end else if (pending_q == '0 && step_out == '0) begin
          state_d = ST_DONE;
          exit_d  = '1;
        end
      end
      default: begin
        exit_d = exit_out;
      end
    endcase
    // Terminal states emit nothing; any remaining count stays in pending.
    if (state_d == ST_DONE || state_d == ST_FAIL) begin
      step_d    = '0;
      pending_d = avail;
    end
    stall_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_out  <= ST_RUN;
      pending_q  <= '0;
      step_out   <= '0;
      exit_out   <= '0;
      stall      <= 1'b0;
      stuck_core <= '0;
      done_q     <= '0;
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        timer_q[i] <= '0;
      end
    end else begin
      state_out  <= state_d;
      pending_q  <= pending_d;
      step_out   <= step_d;
      exit_out   <= exit_d;
      stall      <= stall_d;
      stuck_core <= stuck_d;
      done_q     <= done_d;
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        timer_q[i] <= timer_d[i];
      end
    end
  end

`ifdef DIFFTEST_SYNC_PERF_EN
  // Run-time counters and a one-shot dump pulse on termination.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_run_cycles  <= '0;
      perf_total_steps <= '0;
      perf_dump        <= 1'b0;
    end else begin
      perf_run_cycles  <= perf_run_cycles + 64'(state_out == ST_RUN);
      perf_total_steps <= perf_total_steps + 64'(step_d);
      perf_dump        <= (state_d == ST_DONE || state_d == ST_FAIL) &&
                          !(state_out == ST_DONE || state_out == ST_FAIL);
    end
  end
`endif

endmodule
